// File: rtl/riscv_pkg.sv
// Shared types for the M-extension multiply/divide unit: op encoding,
// FSM states and operand sign helpers.
package riscv_pkg;

    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } m_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } muldiv_state_e;

    function automatic logic is_signed_rs1(m_op_e op);
        return op inside {M_MULH, M_MULHSU, M_DIV, M_REM};
    endfunction

    function automatic logic is_signed_rs2(m_op_e op);
        return op inside {M_MULH, M_DIV, M_REM};
    endfunction

endpackage

// File: rtl/riscv_muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// Ports: is_div, hi/lo (working pair), opnd (multiplicand/divisor) -> hi_n/lo_n.
module riscv_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_n,
    output logic [XLEN-1:0] lo_n
);

    logic [XLEN:0] sum;
    logic [XLEN:0] diff;

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        // partial remainder shifted left by one, minus divisor;
        // top bit set means the trial subtraction went negative
        diff = {hi, lo[XLEN-1]} - {1'b0, opnd};
        if (is_div) begin
            hi_n = diff[XLEN] ? {hi[XLEN-2:0], lo[XLEN-1]}
                              : diff[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// RV32M/RV64M iterative multiply/divide unit, one op in flight, valid/ready
// on both sides. Ports: clk, rst_n, flush, in_* request, out_* result.
// Optional RISCV_MULDIV_FAST_MUL_EN: single-cycle multiplies.
module riscv_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW = $clog2(XLEN + 1);

    muldiv_state_e    state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    m_op_e            op_q, op_d, op_in;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]  hi_n, lo_n;
    logic [XLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             s1, s2, div_in, rem_in;
    logic             zero_div, ovf;
    logic [XLEN-1:0]  mag1, mag2, spec_res;
    logic [XLEN-1:0]  quo_rem, fin_res;
    logic [2*XLEN-1:0] prod, prod_s;

    assign op_in  = m_op_e'(in_op);
    assign s1     = is_signed_rs1(op_in) & in_rs1[XLEN-1];
    assign s2     = is_signed_rs2(op_in) & in_rs2[XLEN-1];
    assign mag1   = s1 ? -in_rs1 : in_rs1;
    assign mag2   = s2 ? -in_rs2 : in_rs2;
    assign div_in = in_op[2];
    assign rem_in = in_op[2] & in_op[1];

    assign zero_div = div_in && (in_rs2 == '0);
    assign ovf = (op_in == M_DIV || op_in == M_REM)
              && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}})
              && (in_rs2 == '1);
    assign spec_res = zero_div ? (rem_in ? in_rs1 : '1)
                               : (rem_in ? '0 : in_rs1);

`ifdef RISCV_MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fa, fb, fp;
    logic [XLEN-1:0] fast_res;
    assign fa = {{XLEN{s1}}, in_rs1};
    assign fb = {{XLEN{s2}}, in_rs2};
    assign fp = fa * fb;
    assign fast_res = (op_in == M_MUL) ? fp[XLEN-1:0]
                                       : fp[2*XLEN-1:XLEN];
`endif

    riscv_muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (op_q[2]),
        .hi     (hi_q),
        .lo     (lo_q),
        .opnd   (opnd_q),
        .hi_n   (hi_n),
        .lo_n   (lo_n)
    );

    // final iteration result, sign-corrected; product is negated as a
    // whole before the low/high half is picked
    assign prod    = {hi_n, lo_n};
    assign prod_s  = neg_q ? -prod : prod;
    assign quo_rem = op_q[1] ? hi_n : lo_n;
    assign fin_res = op_q[2] ? (neg_q ? -quo_rem : quo_rem)
                   : (op_q == M_MUL) ? prod_s[XLEN-1:0]
                                     : prod_s[2*XLEN-1:XLEN];

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        op_d    = op_q;
        neg_d   = neg_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        tag_d   = tag_q;
        unique case (state)
            MD_IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = op_in;
                    tag_d  = in_tag;
                    neg_d  = rem_in ? s1 : (s1 ^ s2);
                    cnt_d  = '0;
                    hi_d   = '0;
                    opnd_d = div_in ? mag2 : mag1;
                    lo_d   = div_in ? mag1 : mag2;
                    if (zero_div || ovf) begin
                        state_d = MD_DONE;
                        res_d   = spec_res;
                    end
`ifdef RISCV_MULDIV_FAST_MUL_EN
                    else if (!div_in) begin
                        state_d = MD_DONE;
                        res_d   = fast_res;
                    end
`endif
                    else begin
                        state_d = MD_BUSY;
                    end
                end
            end
            MD_BUSY: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt + 1'b1;
                if (cnt == CW'(XLEN - 1)) begin
                    state_d = MD_DONE;
                    cnt_d   = '0;
                    res_d   = fin_res;
                end
            end
            MD_DONE: begin
                if (out_ready) state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        if (flush) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            op_q   <= M_MUL;
            neg_q  <= 1'b0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            res_q  <= '0;
            tag_q  <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            op_q   <= op_d;
            neg_q  <= neg_d;
            opnd_q <= opnd_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            res_q  <= res_d;
            tag_q  <= tag_d;
        end
    end

    assign in_ready   = (state == MD_IDLE);
    assign out_valid  = (state == MD_DONE);
    assign out_result = res_q;
    assign out_tag    = tag_q;

endmodule
